// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state encoding and flag-vector layout for the
// sequential ALU family (this block and its pipelined sibling).
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_ROR = 3'b101;
    localparam logic [2:0] OP_ROL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Packed flag vector is {cf, sf, zf, vf}
    localparam int NFLAGS  = 4;
    localparam int FLAG_CF = 3;
    localparam int FLAG_SF = 2;
    localparam int FLAG_ZF = 1;
    localparam int FLAG_VF = 0;

    function automatic logic op_is_rot(input logic [2:0] op);
        return (op == OP_ROR) || (op == OP_ROL);
    endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// Flag generator: sf/zf straight from the result, cf/vf selected per opcode
// from the candidate sources the datapath supplies.
module alu_flag_gen
    import alu_seq_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [2:0]        op,
    input  logic [W-1:0]      r,
    input  logic              arith_cf,
    input  logic              arith_vf,
    input  logic              rot_cf,
    input  logic [W-1:0]      mul_hi,
    output logic [NFLAGS-1:0] flags
);

    logic cf;
    logic vf;

    always_comb begin
        cf = 1'b0;
        vf = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                cf = arith_cf;
                vf = arith_vf;
            end
            OP_ROR, OP_ROL: cf = rot_cf;
            OP_MUL: begin
                cf = |mul_hi;
                vf = |mul_hi;
            end
            default: begin
                cf = 1'b0;
                vf = 1'b0;
            end
        endcase

        flags          = '0;
        flags[FLAG_CF] = cf;
        flags[FLAG_SF] = r[W-1];
        flags[FLAG_ZF] = (r == '0);
        flags[FLAG_VF] = vf;
    end

endmodule

// File: rtl/alu_seq_nbit.sv
// Sequential W-bit ALU: single-cycle add/sub/logic, bit-serial rotates and
// shift-add multiply, with valid/ready handshakes on both sides.
module alu_seq_nbit
    import alu_seq_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [2:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] r,
    output logic         cf,
    output logic         sf,
    output logic         zf,
    output logic         vf
);

    localparam int              SHW     = $clog2(W);
    localparam logic [SHW:0]    CNT_W   = (SHW+1)'(W);
    localparam logic [SHW:0]    CNT_ONE = (SHW+1)'(1);

    state_e              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [W-1:0]        a_q, a_d;
    logic [2*W-1:0]      acc_q, acc_d;
    logic [SHW:0]        cnt_q, cnt_d;
    logic [W-1:0]        r_q, r_d;
    logic [NFLAGS-1:0]   flags_q, flags_d;

    logic                accept;
    logic [SHW-1:0]      amt;
    logic [W:0]          add_ext;
    logic [W:0]          sub_ext;
    logic                add_vf;
    logic                sub_vf;
    logic [W-1:0]        imm_r;
    logic [W:0]          mul_sum;
    logic [2*W-1:0]      step_acc;

    logic                in_exec;
    logic [2:0]          fg_op;
    logic [W-1:0]        fg_r;
    logic                fg_arith_cf;
    logic                fg_arith_vf;
    logic                fg_rot_cf;
    logic [NFLAGS-1:0]   fg_flags;

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign amt       = b[SHW-1:0];
    assign out_valid = (state_q == DONE);
    assign r         = r_q;
    assign cf        = flags_q[FLAG_CF];
    assign sf        = flags_q[FLAG_SF];
    assign zf        = flags_q[FLAG_ZF];
    assign vf        = flags_q[FLAG_VF];

    // Single-cycle datapath works on the live inputs at the accept edge
    always_comb begin
        add_ext = {1'b0, a} + {1'b0, b};
        sub_ext = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
        add_vf  = (a[W-1] == b[W-1]) && (add_ext[W-1] != a[W-1]);
        sub_vf  = (a[W-1] != b[W-1]) && (sub_ext[W-1] != a[W-1]);

        imm_r = a;
        case (op)
            OP_ADD:  imm_r = add_ext[W-1:0];
            OP_SUB:  imm_r = sub_ext[W-1:0];
            OP_AND:  imm_r = a & b;
            OP_OR:   imm_r = a | b;
            OP_XOR:  imm_r = a ^ b;
            default: imm_r = a;
        endcase
    end

    // One iteration step; acc low half is the rotate register or multiplier
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, a_q} : '0);
        step_acc = acc_q;
        case (op_q)
            OP_ROR:  step_acc[W-1:0] = {acc_q[0], acc_q[W-1:1]};
            OP_ROL:  step_acc[W-1:0] = {acc_q[W-2:0], acc_q[W-1]};
            OP_MUL:  step_acc = {mul_sum, acc_q[W-1:1]};
            default: step_acc = acc_q;
        endcase
    end

    always_comb begin
        in_exec     = (state_q == EXEC);
        fg_op       = in_exec ? op_q : op;
        fg_r        = in_exec ? step_acc[W-1:0] : imm_r;
        fg_arith_cf = (op == OP_SUB) ? sub_ext[W] : add_ext[W];
        fg_arith_vf = (op == OP_SUB) ? sub_vf : add_vf;
        fg_rot_cf   = 1'b0;
        if (in_exec) begin
            fg_rot_cf = (op_q == OP_ROR) ? step_acc[W-1] : step_acc[0];
        end
    end

    alu_flag_gen #(.W(W)) u_flag_gen (
        .op       (fg_op),
        .r        (fg_r),
        .arith_cf (fg_arith_cf),
        .arith_vf (fg_arith_vf),
        .rot_cf   (fg_rot_cf),
        .mul_hi   (step_acc[2*W-1:W]),
        .flags    (fg_flags)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        flags_d = flags_q;

        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    op_d = op;
                    a_d  = a;
                    if (op == OP_MUL) begin
                        state_d = EXEC;
                        cnt_d   = CNT_W;
                        acc_d   = {{W{1'b0}}, b};
                    end else if (op_is_rot(op) && (amt != '0)) begin
                        state_d = EXEC;
                        cnt_d   = {1'b0, amt};
                        acc_d   = {{W{1'b0}}, a};
                    end else begin
                        state_d = DONE;
                        r_d     = imm_r;
                        flags_d = fg_flags;
                    end
                end else if ((state_q == DONE) && out_ready) begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                acc_d = step_acc;
                cnt_d = cnt_q - CNT_ONE;
                // The step that drives the counter to zero is the final one
                if (cnt_q <= CNT_ONE) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    r_d     = step_acc[W-1:0];
                    flags_d = fg_flags;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            r_q     <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            flags_q <= flags_d;
        end
    end

endmodule

// File: tb/tb_alu_seq_nbit.sv
// Scoreboard bench for alu_seq_nbit (W=8): directed vectors with hand-computed
// results, flags {cf,sf,zf,vf} and accept-to-valid latency.
module tb_alu_seq_nbit;

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND = 3'd2, OR = 3'd3,
                           XOR = 3'd4, ROR = 3'd5, ROL = 3'd6, MUL = 3'd7;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] r;
    logic       cf, sf, zf, vf;

    typedef struct {
        logic [7:0] r;
        logic [3:0] f;
        int         lat;
        int         acc_cyc;
        string      nm;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   seen = 0;
    int   first_cyc = 0;

    alu_seq_nbit #(.W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r),
        .cf        (cf),
        .sf        (sf),
        .zf        (zf),
        .vf        (vf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called aligned to a falling edge; returns aligned to the falling edge after the accept.
    task automatic issue(input logic [2:0] o, input logic [7:0] ia, input logic [7:0] ib,
                         input logic [7:0] er, input logic [3:0] ef, input int el,
                         input string nm);
        exp_t e;
        int   waited;
        waited   = 0;
        op       = o;
        a        = ia;
        b        = ib;
        in_valid = 1'b1;
        #1;
        while (!in_ready && waited < 60) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s accept: in_ready stuck at 0 for %0d cycles, expected 1", nm, waited);
            @(negedge clk);
            in_valid = 1'b0;
        end else begin
            e.r       = er;
            e.f       = ef;
            e.lat     = el;
            e.acc_cyc = cyc;
            e.nm      = nm;
            q.push_back(e);
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", q.size(), 0);
    endtask

    // Monitor: samples between edges, pops on each output handshake
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst_n) begin
            seen = 0;
        end else if (out_valid) begin
            if (seen == 0) begin
                seen      = 1;
                first_cyc = cyc;
            end
            if (q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL spurious_out: got r=0x%0h with out_valid=1, expected no result", r);
            end else if (out_ready) begin
                e = q.pop_front();
                check({e.nm, "_r"}, r, e.r);
                check({e.nm, "_flags"}, {cf, sf, zf, vf}, e.f);
                check({e.nm, "_lat"}, first_cyc - e.acc_cyc, e.lat);
                seen = 0;
            end else begin
                check({q[0].nm, "_stall_r"}, r, q[0].r);
                check({q[0].nm, "_stall_flags"}, {cf, sf, zf, vf}, q[0].f);
                check({q[0].nm, "_stall_in_ready"}, in_ready, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        op        = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_r", r, 0);
        check("rst_flags", {cf, sf, zf, vf}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single-cycle ops, issued back to back
        issue(ADD, 8'h7F, 8'h01, 8'h80, 4'b0101, 1, "add_ovf");
        issue(SUB, 8'h05, 8'h05, 8'h00, 4'b1010, 1, "sub_zero");
        issue(SUB, 8'h00, 8'h01, 8'hFF, 4'b0100, 1, "sub_borrow");
        issue(ADD, 8'hFF, 8'h01, 8'h00, 4'b1010, 1, "add_carry");
        issue(ADD, 8'h80, 8'h80, 8'h00, 4'b1011, 1, "add_negovf");
        issue(SUB, 8'h80, 8'h01, 8'h7F, 4'b1001, 1, "sub_ovf");
        issue(AND, 8'hF0, 8'h3C, 8'h30, 4'b0000, 1, "and");
        issue(OR,  8'h0F, 8'hF0, 8'hFF, 4'b0100, 1, "or");
        issue(XOR, 8'hAA, 8'hAA, 8'h00, 4'b0010, 1, "xor");

        // Rotates
        issue(ROR, 8'h01, 8'h03, 8'h20, 4'b0000, 4, "ror3");
        issue(ROL, 8'h81, 8'h01, 8'h03, 4'b1000, 2, "rol1");
        issue(ROR, 8'hA5, 8'h00, 8'hA5, 4'b0100, 1, "ror0");
        issue(ROR, 8'h5A, 8'h08, 8'h5A, 4'b0000, 1, "ror_b8");
        issue(ROL, 8'h01, 8'h07, 8'h80, 4'b0100, 8, "rol7");

        // Multiply
        issue(MUL, 8'h10, 8'h10, 8'h00, 4'b1011, 9, "mul_10x10");
        issue(MUL, 8'h0F, 8'h03, 8'h2D, 4'b0000, 9, "mul_0fx03");
        issue(MUL, 8'hFF, 8'hFF, 8'h01, 4'b1001, 9, "mul_ffxff");
        drain();

        // Back-pressure, then release together with a new op
        out_ready = 1'b0;
        issue(ADD, 8'h02, 8'h03, 8'h05, 4'b0000, 1, "bp_hold");
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
        issue(OR, 8'h0C, 8'h03, 8'h0F, 4'b0000, 1, "bp_b2b");
        drain();

        // in_valid pulses while iterating must be ignored
        issue(MUL, 8'h0F, 8'h03, 8'h2D, 4'b0000, 9, "mul_ignore");
        repeat (2) begin
            op       = ADD;
            a        = 8'h01;
            b        = 8'h01;
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            @(negedge clk);
        end
        drain();

        // Reset during multiply iteration
        issue(MUL, 8'h10, 8'h10, 8'h00, 4'b1011, 9, "mul_rst");
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_r", r, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_flags", {cf, sf, zf, vf}, 0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        issue(ADD, 8'h02, 8'h03, 8'h05, 4'b0000, 1, "add_after_rst");
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
